// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice: default widths and the
// clear-sequencer state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry of the register file writing zero after
// reset or on request, then hands the file over to normal operation.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    rf_state_t         state;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;

    // State and clear index registers; reset always restarts the clear walk
    // from entry 0, whatever the sequencer was doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RF_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic and outputs. In CLEAR one entry is zeroed per cycle and
    // the last entry moves us to RUN, so CLEAR lasts exactly DEPTH cycles. In
    // RUN a clear request restarts the walk; ready reflects RUN directly.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        ready      = 1'b0;
        clr_we     = 1'b0;
        clr_addr   = idx;
        case (state)
            RF_CLEAR: begin
                clr_we   = 1'b1;
                idx_next = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = RF_RUN;
                    idx_next   = '0;
                end
            end
            RF_RUN: begin
                ready = 1'b1;
                if (clr_req) begin
                    state_next = RF_CLEAR;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = RF_CLEAR;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_bypass.sv
// Two-read / one-write register file with registered read ports, optional
// same-cycle write forwarding, optional hardwired zero register and a
// hardware clear sequencer in place of file-based initialisation.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              port_we;
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A port write is honoured only in RUN; writes to entry 0 are dropped when
    // it is hardwired to zero.
    always_comb begin
        port_we = ready && wr_en;
        if ((ZERO_REG != 0) && (wr_addr == '0)) begin
            port_we = 1'b0;
        end
    end

    // Storage array, not reset: the clear sequencer has priority and zeroes
    // one entry per cycle, otherwise the port write lands.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (port_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-side value selection for both ports: zero register wins over
    // everything, then the in-flight write is forwarded when enabled, else the
    // stored contents (which are still the pre-write value this cycle).
    always_comb begin
        rs_next = mem[rs_addr];
        rt_next = mem[rt_addr];
        if ((BYPASS != 0) && wr_en && (wr_addr == rs_addr)) begin
            rs_next = wr_data;
        end
        if ((BYPASS != 0) && wr_en && (wr_addr == rt_addr)) begin
            rt_next = wr_data;
        end
        if ((ZERO_REG != 0) && (rs_addr == '0)) begin
            rs_next = '0;
        end
        if ((ZERO_REG != 0) && (rt_addr == '0)) begin
            rt_next = '0;
        end
    end

    // Registered read ports: capture on rd_en while in RUN, hold otherwise,
    // and clear immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_data <= '0;
            rt_data <= '0;
        end else if (ready && rd_en) begin
            rs_data <= rs_next;
            rt_data <= rt_next;
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass: a directed vector table for the
// basic read/write/bypass/zero cases, hand sequences for clear and reset,
// and a randomized run checked against a behavioural model every cycle.
module tb_regfile_bypass;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 32;
    localparam int ZERO_REG = 1;
    localparam int BYPASS   = 1;

    logic              clk;
    logic              rst;
    logic              rd_en;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              ready;

    int total;
    int bad;

    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_busy;
    logic [DATA_W-1:0] m_rs;
    logic [DATA_W-1:0] m_rt;

    typedef struct packed {
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              rd_en;
        logic [ADDR_W-1:0] rs_addr;
        logic [ADDR_W-1:0] rt_addr;
        logic [DATA_W-1:0] exp_rs;
        logic [DATA_W-1:0] exp_rt;
    } vec_t;

    vec_t vecs [8];

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr_req (clr_req),
        .ready   (ready)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison, counted; prints a FAIL line on disagreement.
    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read of address a returns given the inputs present at the edge.
    function automatic logic [DATA_W-1:0] readModel(input logic [ADDR_W-1:0] a);
        if (ZERO_REG != 0 && a == 0) return '0;
        if (BYPASS != 0 && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    // Model reaction to one rising edge. A clear is modelled as "file becomes
    // all zero and the block is busy for DEPTH cycles"; nothing inside the
    // file is observable while busy, so when the zeroing happens is moot.
    task automatic modelEdge();
        if (rst) return;
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (rd_en) begin
                m_rs = readModel(rs_addr);
                m_rt = readModel(rt_addr);
            end
            if (wr_en && !(ZERO_REG != 0 && wr_addr == 0)) m_mem[wr_addr] = wr_data;
            if (clr_req) begin
                m_busy = DEPTH;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end
    endtask

    task automatic modelReset();
        m_busy = DEPTH;
        m_rs   = '0;
        m_rt   = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
    endtask

    // Compare all outputs against the model.
    task automatic checkOutput(input string tag);
        check({tag, ".ready"}, {31'd0, ready}, {31'd0, (m_busy == 0) && !rst});
        check({tag, ".rs"}, rs_data, m_rs);
        check({tag, ".rt"}, rt_data, m_rt);
    endtask

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input logic re, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                                 input logic clr);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rs_addr = ra;
        rt_addr = rb;
        clr_req = clr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Advance one cycle: model the edge, then sample 1 ns after it.
    task automatic stepClock(input string tag);
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Asynchronous reset pulse; outputs must clear without waiting for a clock.
    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        check("rst.rs_now", rs_data, '0);
        check("rst.rt_now", rt_data, '0);
        check("rst.ready_now", {31'd0, ready}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Count cycles with ready low; optionally hammer writes that must be lost.
    task automatic countNotReady(input string tag, input bit junk_writes);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            if (junk_writes)
                applyStimulus(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1,
                              5'($urandom), 5'($urandom), 1'b0);
            else
                idle();
            stepClock(tag);
            n++;
        end
        idle();
        check({tag, ".clear_len"}, n, 32);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        modelReset();

        // Reset, then idle through the clear; every entry reads zero.
        #2;
        doReset();
        countNotReady("t1", 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 5'(a), 5'(DEPTH - 1 - a), 1'b0);
            stepClock("t1.read");
            check("t1.zero_rs", rs_data, '0);
            check("t1.zero_rt", rt_data, '0);
        end

        // Directed vectors: basic write/read, double bypass, zero register.
        vecs[0] = '{1'b1, 5'd5, 32'h0000_0045, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd0, 32'h45, 32'h0};
        vecs[2] = '{1'b1, 5'd2, 32'hDEAD_BEEF, 1'b1, 5'd2, 5'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd2, 5'd5, 32'hDEAD_BEEF, 32'h45};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd2, 32'h0, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 5'd7, 32'h0000_0123, 1'b0, 5'd7, 5'd7, 32'h0, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 5'd7, 32'h0000_0055, 1'b1, 5'd7, 5'd5, 32'h55, 32'h45};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
                          vecs[i].rd_en, vecs[i].rs_addr, vecs[i].rt_addr, 1'b0);
            stepClock("vec");
            check($sformatf("vec%0d.rs", i), rs_data, vecs[i].exp_rs);
            check($sformatf("vec%0d.rt", i), rt_data, vecs[i].exp_rt);
        end

        // Clear request, then reset at clear cycle 10: outputs drop at once
        // and the clear restarts for a full 32 cycles.
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        stepClock("t6.req");
        idle();
        for (int c = 0; c < 10; c++) stepClock("t6.clr");
        check("t6.rs_held", rs_data, 32'h55);
        doReset();
        countNotReady("t6", 1'b0);

        // Fill r1..r31, clear with a coincident write, write junk during the
        // clear, then every entry must read zero.
        for (int a = 1; a < DEPTH; a++) begin
            applyStimulus(1'b1, 5'(a), $urandom | 32'h1, 1'b0, '0, '0, 1'b0);
            stepClock("t5.fill");
        end
        applyStimulus(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, '0, '0, 1'b1);
        stepClock("t5.req");
        countNotReady("t5", 1'b1);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 5'(a), 5'(a), 1'b0);
            stepClock("t5.read");
            check("t5.zero", rs_data, '0);
        end

        // Randomized traffic with occasional clear requests.
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), $urandom_range(0, 59) == 0);
            stepClock("rand");
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
